// File: rtl/isa_shared.sv
// Shared types for the execute-stage result path.
// Holds the buffered ALU result record and buffer occupancy states.
package isa_shared;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            carry;
    logic            overflow;
    logic [4:0]      rd;
    logic            we;
  } ex_result_t;

  typedef enum logic [1:0] {
    EXB_EMPTY,
    EXB_ONE,
    EXB_FULL
  } exbuf_state_t;

endpackage

// File: rtl/fwd_match.sv
// Two-entry forwarding compare for one source register.
// The younger (tail) entry takes priority over the head.
module fwd_match
  import isa_shared::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic [4:0]            addr,
  input  logic                  head_valid,
  input  logic                  head_we,
  input  logic [4:0]            head_rd,
  input  logic [DATA_WIDTH-1:0] head_data,
  input  logic                  tail_valid,
  input  logic                  tail_we,
  input  logic [4:0]            tail_rd,
  input  logic [DATA_WIDTH-1:0] tail_data,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] data
);

  logic head_m;
  logic tail_m;

  assign head_m = head_valid && head_we
               && (head_rd == addr);
  assign tail_m = tail_valid && tail_we
               && (tail_rd == addr);

  always_comb begin
    hit  = head_m | tail_m;
    data = '0;
    if (tail_m) begin
      data = tail_data;
    end else if (head_m) begin
      data = head_data;
    end
  end

endmodule

// File: rtl/ex_result_buffer.sv
// Two-entry skid FIFO between ALU and writeback,
// with register forwarding from the buffered entries.
module ex_result_buffer
  import isa_shared::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_zero,
  input  logic                  in_carry,
  input  logic                  in_overflow,
  input  logic [4:0]            in_rd,
  input  logic                  in_we,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_carry,
  output logic                  out_overflow,
  output logic [4:0]            out_rd,
  output logic                  out_we,
  input  logic                  flush,
  input  logic [4:0]            fwd_rs1_addr,
  input  logic [4:0]            fwd_rs2_addr,
  output logic                  fwd_rs1_hit,
  output logic                  fwd_rs2_hit,
  output logic [DATA_WIDTH-1:0] fwd_rs1_data,
  output logic [DATA_WIDTH-1:0] fwd_rs2_data
);

  exbuf_state_t state;
  ex_result_t   head;
  ex_result_t   tail;
  ex_result_t   in_entry;
  logic         push;
  logic         pop;
  logic         tail_valid;

  assign in_ready   = (state != EXB_FULL);
  assign out_valid  = (state != EXB_EMPTY);
  assign tail_valid = (state == EXB_FULL);
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;

  // x0 writes are squashed at capture time
  assign in_entry = '{
    result:   in_result,
    zero:     in_zero,
    carry:    in_carry,
    overflow: in_overflow,
    rd:       in_rd,
    we:       in_we && (in_rd != 5'd0)
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EXB_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      state <= EXB_EMPTY;
    end else begin
      unique case (state)
        EXB_EMPTY: begin
          if (push) begin
            head  <= in_entry;
            state <= EXB_ONE;
          end
        end
        EXB_ONE: begin
          unique case ({push, pop})
            2'b10: begin
              tail  <= in_entry;
              state <= EXB_FULL;
            end
            2'b11: head  <= in_entry;
            2'b01: state <= EXB_EMPTY;
            default: ;
          endcase
        end
        EXB_FULL: begin
          if (pop) begin
            head  <= tail;
            state <= EXB_ONE;
          end
        end
        default: state <= EXB_EMPTY;
      endcase
    end
  end

  assign out_result   = head.result;
  assign out_zero     = head.zero;
  assign out_carry    = head.carry;
  assign out_overflow = head.overflow;
  assign out_rd       = head.rd;
  assign out_we       = head.we;

  fwd_match #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs1 (
    .addr       (fwd_rs1_addr),
    .head_valid (out_valid),
    .head_we    (head.we),
    .head_rd    (head.rd),
    .head_data  (head.result),
    .tail_valid (tail_valid),
    .tail_we    (tail.we),
    .tail_rd    (tail.rd),
    .tail_data  (tail.result),
    .hit        (fwd_rs1_hit),
    .data       (fwd_rs1_data)
  );

  fwd_match #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs2 (
    .addr       (fwd_rs2_addr),
    .head_valid (out_valid),
    .head_we    (head.we),
    .head_rd    (head.rd),
    .head_data  (head.result),
    .tail_valid (tail_valid),
    .tail_we    (tail.we),
    .tail_rd    (tail.rd),
    .tail_data  (tail.result),
    .hit        (fwd_rs2_hit),
    .data       (fwd_rs2_data)
  );

endmodule

// File: tb/tb_ex_result_buffer.sv
// Bench for ex_result_buffer: queue model checked every
// cycle plus directed literal checks.
module tb_ex_result_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zero;
  logic        in_carry;
  logic        in_overflow;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_carry;
  logic        out_overflow;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        flush;
  logic [4:0]  fwd_rs1_addr;
  logic [4:0]  fwd_rs2_addr;
  logic        fwd_rs1_hit;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_rs1_data;
  logic [31:0] fwd_rs2_data;

  ex_result_buffer #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_zero      (in_zero),
    .in_carry     (in_carry),
    .in_overflow  (in_overflow),
    .in_rd        (in_rd),
    .in_we        (in_we),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .out_rd       (out_rd),
    .out_we       (out_we),
    .flush        (flush),
    .fwd_rs1_addr (fwd_rs1_addr),
    .fwd_rs2_addr (fwd_rs2_addr),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_data (fwd_rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [2:0]  f;
    logic [4:0]  rd;
    logic        we;
  } ent_t;

  ent_t q[$];
  ent_t m_e;
  bit   m_push;
  bit   m_pop;

  // Model: an ordered list of at most two results.
  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) begin
        q.delete();
      end else begin
        m_push = in_valid && (q.size() < 2);
        m_pop  = (q.size() > 0) && out_ready;
        m_e.d  = in_result;
        m_e.f  = {in_zero, in_carry, in_overflow};
        m_e.rd = in_rd;
        m_e.we = in_we && (in_rd != 5'd0);
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(m_e);
      end
    end
  end

  always @(negedge rst_n) q.delete();

  function automatic void fwd(input logic [4:0] a,
                              output logic h,
                              output logic [31:0] d);
    h = 1'b0;
    d = 32'h0;
    foreach (q[i]) begin
      if (q[i].we && q[i].rd == a) begin
        h = 1'b1;
        d = q[i].d;
      end
    end
  endfunction

  logic        e_h1, e_h2;
  logic [31:0] e_d1, e_d2;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_result", out_result, 0);
      chk("rst_hits", {fwd_rs1_hit, fwd_rs2_hit}, 0);
    end else begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("out_result", out_result, q[0].d);
        chk("out_flags",
            {out_zero, out_carry, out_overflow}, q[0].f);
        chk("out_rd", out_rd, q[0].rd);
        chk("out_we", out_we, q[0].we);
      end
      fwd(fwd_rs1_addr, e_h1, e_d1);
      fwd(fwd_rs2_addr, e_h2, e_d2);
      chk("rs1_hit", fwd_rs1_hit, e_h1);
      chk("rs1_data", fwd_rs1_data, e_d1);
      chk("rs2_hit", fwd_rs2_hit, e_h2);
      chk("rs2_data", fwd_rs2_data, e_d2);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] d,
                       input logic [4:0] rd,
                       input logic we);
    in_valid    = v;
    in_result   = d;
    in_rd       = rd;
    in_we       = we;
    in_zero     = d[4];
    in_carry    = d[0];
    in_overflow = d[1];
  endtask

  initial begin
    rst_n        = 1'b0;
    drive(0, 0, 0, 0);
    out_ready    = 1'b0;
    flush        = 1'b0;
    fwd_rs1_addr = 5'd0;
    fwd_rs2_addr = 5'd0;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_result", out_result, 0);
    chk("reset_out_rd", out_rd, 0);
    chk("reset_hits", {fwd_rs1_hit, fwd_rs2_hit}, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();

    // single push then pop
    drive(1, 32'h5, 5'd3, 1);
    out_ready = 1'b1;
    step();
    drive(0, 0, 0, 0);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_result", out_result, 32'h5);
    chk("t1_out_rd", out_rd, 3);
    chk("t1_out_we", out_we, 1);
    step();
    chk("t1_empty", out_valid, 0);

    // fill, ignored third push, ordered drain
    out_ready = 1'b0;
    drive(1, 32'hA, 5'd1, 1);
    step();
    drive(1, 32'hB, 5'd2, 1);
    step();
    chk("t2_full_in_ready", in_ready, 0);
    chk("t2_head_a", out_result, 32'hA);
    drive(1, 32'hC, 5'd4, 1);
    step();
    chk("t2_hold_a", out_result, 32'hA);
    chk("t2_still_full", in_ready, 0);
    drive(0, 0, 0, 0);
    out_ready = 1'b1;
    step();
    chk("t2_then_b", out_result, 32'hB);
    chk("t2_b_valid", out_valid, 1);
    step();
    chk("t2_drained", out_valid, 0);

    // push and pop together in ONE
    out_ready = 1'b0;
    drive(1, 32'hA, 5'd1, 1);
    step();
    drive(1, 32'hB, 5'd2, 1);
    out_ready = 1'b1;
    step();
    drive(0, 0, 0, 0);
    chk("t3_valid", out_valid, 1);
    chk("t3_result_b", out_result, 32'hB);
    chk("t3_in_ready", in_ready, 1);
    step();
    chk("t3_empty", out_valid, 0);

    // forwarding priority and x0
    out_ready = 1'b0;
    drive(1, 32'h11, 5'd7, 1);
    step();
    drive(1, 32'h22, 5'd7, 1);
    step();
    drive(0, 0, 0, 0);
    fwd_rs1_addr = 5'd7;
    fwd_rs2_addr = 5'd5;
    #1;
    chk("t4_rs1_hit", fwd_rs1_hit, 1);
    chk("t4_rs1_data", fwd_rs1_data, 32'h22);
    chk("t4_rs2_hit", fwd_rs2_hit, 0);
    chk("t4_rs2_data", fwd_rs2_data, 0);
    out_ready = 1'b1;
    step();
    step();
    chk("t4_empty", out_valid, 0);
    out_ready = 1'b0;
    drive(1, 32'h33, 5'd0, 1);
    fwd_rs1_addr = 5'd0;
    step();
    drive(0, 0, 0, 0);
    chk("t4_x0_valid", out_valid, 1);
    chk("t4_x0_we", out_we, 0);
    chk("t4_x0_hit", fwd_rs1_hit, 0);

    // flush in FULL beats push
    drive(1, 32'h44, 5'd6, 1);
    step();
    chk("t5_full", in_ready, 0);
    drive(1, 32'h55, 5'd8, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 0, 0, 0);
    chk("t5_flush_empty", out_valid, 0);
    chk("t5_flush_ready", in_ready, 1);
    step();
    chk("t5_push_lost", out_valid, 0);

    // async reset while FULL
    drive(1, 32'h66, 5'd9, 1);
    step();
    drive(1, 32'h77, 5'd10, 1);
    step();
    drive(0, 0, 0, 0);
    fwd_rs1_addr = 5'd9;
    #1;
    chk("t5_full2", in_ready, 0);
    chk("t5_pre_hit", fwd_rs1_hit, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_result", out_result, 0);
    chk("t5_rst_hit", fwd_rs1_hit, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1, 32'h88, 5'd2, 1);
    step();
    drive(0, 0, 0, 0);
    chk("t5_after_valid", out_valid, 1);
    chk("t5_after_result", out_result, 32'h88);
    chk("t5_after_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("t5_after_empty", out_valid, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_result_buffer.md
EX_RESULT_BUFFER -- requirements
Module: ex_result_buffer

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, the width of the result datapath.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL provide in_valid, input, 1: the ALU stage presents a result this cycle.
REQ-005 SHALL provide in_ready, output, 1: the buffer accepts a result this cycle.
REQ-006 SHALL provide in_result, input, DATA_WIDTH: the ALU result.
REQ-007 SHALL provide in_zero / in_carry / in_overflow, input, 1 each: the ALU flags.
REQ-008 SHALL provide in_rd, input, 5, destination register index, and in_we, input, 1, register-write request.
REQ-009 SHALL provide out_valid, output, 1, and out_ready, input, 1: handshake to writeback.
REQ-010 SHALL provide out_result (DATA_WIDTH), out_zero, out_carry, out_overflow, out_rd (5) and out_we (1), all outputs, carrying the head entry.
REQ-011 SHALL provide flush, input, 1: discard all buffered entries.
REQ-012 SHALL provide fwd_rs1_addr and fwd_rs2_addr, inputs, 5 each: decode-stage source registers.
REQ-013 SHALL provide fwd_rs1_hit and fwd_rs2_hit, outputs, 1 each, plus fwd_rs1_data and fwd_rs2_data, outputs, DATA_WIDTH each: forwarding results.

Function
REQ-014 SHALL be a 2-entry FIFO (head, tail) with states EMPTY, ONE and FULL.
REQ-015 SHALL accept (push) on a cycle where in_valid and in_ready are both high, and SHALL release (pop) on a cycle where out_valid and out_ready are both high.
REQ-016 SHALL drive in_ready = (state != FULL), decoded from registered state only, with no combinational path from out_ready.
REQ-017 SHALL drive out_valid = (state != EMPTY); out_* SHALL come from the head register.
REQ-018 SHALL give a result pushed at edge t visibility at out_* after edge t, i.e. one-cycle latency, with no same-cycle bypass.
REQ-019 SHALL make these transitions:
  - EMPTY + push -> ONE.
  - ONE + push without pop -> FULL.
  - ONE + pop without push -> EMPTY.
  - ONE + push + pop -> ONE, with the new entry becoming head.
  - FULL + pop -> ONE, with tail moving to head.
  - FULL ignores in_valid.
REQ-020 SHALL store we as in_we && (in_rd != 0), so writes to x0 are never emitted.
REQ-021 SHALL hold out_* stable while out_valid is high and out_ready is low.
REQ-022 SHALL, on flush, go to EMPTY at the next edge; flush outranks a same-cycle push or pop; any push on that cycle is dropped.
REQ-023 SHALL assert fwd_rsN_hit when a valid entry has we=1 and rd=fwd_rsN_addr; when both entries match, tail (younger) data SHALL win; otherwise fwd_rsN_data = 0.
REQ-024 SHALL leave the forwarding outputs combinational from the entries and addresses; they SHALL NOT depend on in_* of the current cycle.
REQ-025 SHALL NOT modify data: result and flags are stored bit-exact.

Reset
REQ-026 SHALL, while rst_n is low, immediately force state = EMPTY, out_valid = 0, in_ready = 1, and all entry fields, out_* and fwd_*_hit to 0.
REQ-027 SHALL discard in-flight entries on a reset asserted mid-operation, with no pop reported; the first push after rst_n rises SHALL behave as from EMPTY.

Structure
REQ-028 SHALL have typedefs in package isa_shared: ex_result_t (result, zero, carry, overflow, rd, we) and enum exbuf_state_t {EXB_EMPTY, EXB_ONE, EXB_FULL}.
REQ-029 SHALL use one sub-module, fwd_match (two-entry priority compare), instantiated once per source port.

Verification
REQ-030 SHALL cover: push 0x0000_0005 rd=3 we=1 from EMPTY with out_ready=1 -> out_valid=1 next cycle, out_result=5, out_rd=3; EMPTY after the pop.
REQ-031 SHALL cover: out_ready=0, push 0xA then 0xB -> FULL and in_ready=0; a third push is ignored; raising out_ready -> 0xA then 0xB, in order.
REQ-032 SHALL cover: ONE holding 0xA, simultaneous push 0xB and pop -> state stays ONE and out_result=0xB next cycle.
REQ-033 SHALL cover: entries rd=7 data 0x11 (head) and rd=7 data 0x22 (tail), fwd_rs1_addr=7 -> hit=1, data=0x22; push with rd=0 we=1 -> out_we=0 and fwd hit=0 for addr 0.
REQ-034 SHALL cover: FULL with flush=1 and in_valid=1 -> EMPTY next cycle and pushed data lost; rst_n pulsed low mid-cycle in FULL -> out_valid drops immediately.
